// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - address map, register offsets and field indices shared by data-bus peripherals
// Each peripheral owns a 32-byte window; registers are word-aligned within it.
package mmio_pkg;

  localparam logic [31:0] TIMER_BASE = 32'h4000_0000;
  localparam int unsigned WIN_LSB    = 5;

  localparam logic [4:0] OFF_TH      = 5'h00;
  localparam logic [4:0] OFF_TL      = 5'h04;
  localparam logic [4:0] OFF_TCON    = 5'h08;
  localparam logic [4:0] OFF_SYSTICK = 5'h0C;

  // Word indices as seen on Addr[4:2]
  localparam logic [2:0] IDX_TH      = OFF_TH[4:2];
  localparam logic [2:0] IDX_TL      = OFF_TL[4:2];
  localparam logic [2:0] IDX_TCON    = OFF_TCON[4:2];
  localparam logic [2:0] IDX_SYSTICK = OFF_SYSTICK[4:2];

  localparam int unsigned TCON_EN = 0;
  localparam int unsigned TCON_IE = 1;
  localparam int unsigned TCON_ST = 2;
  localparam int unsigned TCON_W  = 3;

  typedef struct packed {
    logic       hit;
    logic       rd;
    logic       wr;
    logic [2:0] idx;
  } bus_dec_t;

endpackage

// File: rtl/reload_counter.sv
// rtl/reload_counter.sv - TL up-counter with TH reload on overflow and bus write override
// ovf_o is high in the cycle where TL is all-ones while counting; the reload lands at the closing edge.
module reload_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         th_we_i,
  input  logic         tl_we_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] th_o,
  output logic [W-1:0] tl_o,
  output logic         ovf_o
);

  logic [W-1:0] th_q, th_d;
  logic [W-1:0] tl_q, tl_d;

  assign ovf_o = en_i && (tl_q == '1);
  assign th_o  = th_q;
  assign tl_o  = tl_q;

  always_comb begin
    th_d = th_q;
    tl_d = tl_q;
    if (th_we_i) th_d = wdata_i;
    // Reload reads th_q, so a TH store in the same cycle only affects the next reload
    if (tl_we_i)     tl_d = wdata_i;
    else if (ovf_o)  tl_d = th_q;
    else if (en_i)   tl_d = tl_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      th_q <= '0;
      tl_q <= '0;
    end else begin
      th_q <= th_d;
      tl_q <= tl_d;
    end
  end

endmodule

// File: rtl/irq_timer.sv
// rtl/irq_timer.sv - memory-mapped interval timer raising IRQ on TL overflow, masked in kernel mode
// Holds bus decode, TCON, SYSTICK, the read mux and IRQ gating; TL/TH live in reload_counter.
module irq_timer
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = TIMER_BASE,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       Addr,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  input  logic              Supervisor,
  output logic              IRQ
);

  bus_dec_t dec;

  logic [TCON_W-1:0] tcon_q, tcon_d;
  logic [DATA_W-1:0] systick_q, systick_d;
  logic [DATA_W-1:0] th, tl;
  logic              ovf;
  logic              th_we, tl_we, tcon_we;
  logic [DATA_W-1:0] rdata;
  logic              unused_addr;

  assign unused_addr = ^Addr[1:0];

  always_comb begin
    dec     = '0;
    dec.hit = (Addr[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);
    dec.idx = Addr[4:2];
    dec.rd  = MemRead  & dec.hit;
    dec.wr  = MemWrite & dec.hit;
  end

  assign th_we   = dec.wr && (dec.idx == IDX_TH);
  assign tl_we   = dec.wr && (dec.idx == IDX_TL);
  assign tcon_we = dec.wr && (dec.idx == IDX_TCON);

  reload_counter #(.W(DATA_W)) u_counter (
    .clk     (clk),
    .rst_n   (reset),
    .en_i    (tcon_q[TCON_EN]),
    .th_we_i (th_we),
    .tl_we_i (tl_we),
    .wdata_i (WriteData),
    .th_o    (th),
    .tl_o    (tl),
    .ovf_o   (ovf)
  );

  // Overflow is applied after the store so a racing ST=0 write cannot lose an interrupt
  always_comb begin
    tcon_d = tcon_q;
    if (tcon_we) tcon_d = WriteData[TCON_W-1:0];
    if (ovf)     tcon_d[TCON_ST] = 1'b1;
  end

  assign systick_d = systick_q + DATA_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcon_q    <= '0;
      systick_q <= '0;
    end else begin
      tcon_q    <= tcon_d;
      systick_q <= systick_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (dec.idx)
      IDX_TH:      rdata = th;
      IDX_TL:      rdata = tl;
      IDX_TCON:    rdata = DATA_W'(tcon_q);
      IDX_SYSTICK: rdata = systick_q;
      default:     rdata = '0;
    endcase
  end

  assign ReadData = dec.rd ? rdata : '0;
  assign IRQ      = tcon_q[TCON_IE] & tcon_q[TCON_ST] & ~Supervisor;

endmodule

// File: doc/irq_timer.md
# irq_timer

Memory-mapped interval timer that generates the `IRQ` input consumed by the pipeline controller. It sits on the data-memory bus beside data RAM, is programmed by software through load/store, and asserts `IRQ` on counter overflow until software clears the status bit. It masks `IRQ` while the CPU runs in kernel mode so the controller never sees a nested interrupt.

## Interface

**Parameters**
- `BASE_ADDR`, default 32'h4000_0000: base of the 32-byte peripheral window.
- `DATA_W`, default 32: register and bus width.

**Ports**
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: asynchronous, active-low; clears all state.
- `MemRead`, input, 1: load access this cycle.
- `MemWrite`, input, 1: store access this cycle.
- `Addr`, input, 32: byte address from the MEM stage.
- `WriteData`, input, DATA_W: store data.
- `ReadData`, output, DATA_W: load data; 0 when not selected.
- `Supervisor`, input, 1: PC[31] of the current instruction (kernel mode). 1 masks `IRQ`.
- `IRQ`, output, 1: interrupt request to the controller.

## Operation

- The window is selected when `Addr[31:5] == BASE_ADDR[31:5]`. The register is chosen by `Addr[4:2]`; `Addr[1:0]` is ignored.
- Register map:
  - 0x00 TH: reload value, R/W.
  - 0x04 TL: counter, R/W.
  - 0x08 TCON: bits [2:0] R/W, bits [31:3] read 0.
  - 0x0C SYSTICK: free-running cycle count, read-only; writes ignored.
  - Other offsets read 0 and ignore writes.
- TCON bits:
  - [0] EN: counting enable.
  - [1] IE: interrupt enable.
  - [2] ST: overflow status.
- Counting:
  - While EN=1, TL increments by 1 each cycle.
  - When TL == all-ones and EN=1, the next TL is TH (reload, no wrap to 0), and ST is set.
  - ST is set on overflow regardless of IE.
- `IRQ = IE & ST & ~Supervisor` is combinational from registers. It stays high until software writes ST=0 or IE=0.
- SYSTICK increments every cycle from reset and wraps from all-ones to 0.
- Reads are combinational. `ReadData` shows the current register value when `MemRead=1` and the window is selected; otherwise it is 0.
- Simultaneous-event priorities:
  - Store to TL in the same cycle as an overflow: the store wins and ST is still set.
  - Store to TCON writing ST=0 in the same cycle as an overflow: ST ends at 1, so no interrupt is lost.
  - Store to TH in the same cycle as a reload: the reload uses the old TH; the new TH applies from the next reload.
  - `MemRead` and `MemWrite` together: the write commits at the edge, and `ReadData` shows the pre-write value.
- Reset mid-count: all registers clear immediately (asynchronous). `IRQ` drops in the same cycle as `reset` asserts.

## Timing

- Reset values: TH=0, TL=0, TCON=0, SYSTICK=0, `IRQ`=0, `ReadData`=0.
- Write latency: the register holds the new value one cycle after the store cycle (updated at the closing edge).
- Read latency: 0 cycles, same cycle as `MemRead`.
- Overflow to IRQ: if TL = all-ones at edge k with EN=IE=1, then ST=1 and `IRQ`=1 in the cycle following edge k.
- Overflow period: with EN=1 and TH=N, overflows occur every (2^32 − N) cycles.
- IRQ clear: a store writing ST=0 at edge k drops `IRQ` in the cycle following edge k.
- Supervisor masking: `Supervisor` affects `IRQ` within the same cycle, with no register in the path.

## Structure

- Shared package `mmio_pkg` holds:
  - `TIMER_BASE`.
  - Offsets `OFF_TH`, `OFF_TL`, `OFF_TCON`, `OFF_SYSTICK`.
  - TCON bit indices `TCON_EN`, `TCON_IE`, `TCON_ST`.
- `mmio_pkg` is shared with future peripherals (LED, UART) that use the same bus.
- One sub-module is natural: `reload_counter` (TL, TH reload, overflow pulse, write-override port).
- `irq_timer` holds the address decode, TCON, SYSTICK, the read mux and the IRQ gating.

## Test plan

- **Reset:** drive `reset`=0 mid-count. Required: all registers read 0 and `IRQ`=0 in the same cycle; after release, SYSTICK reads 1 one cycle later.
- **Basic overflow:** TH=0xFFFFFFFC, TL=0xFFFFFFFC, TCON=3. Required: ST=1 and `IRQ`=1 exactly 4 cycles after the TCON write commits; TL reads 0xFFFFFFFC the cycle after overflow; the next overflow follows 4 cycles later.
- **Clear race:** store TCON=3 (ST=0) in the overflow cycle. Required: TCON reads 7 afterwards and `IRQ` stays 1.
- **Supervisor mask:** ST=IE=1, toggle `Supervisor` 0→1→0. Required: `IRQ` follows 1→0→1 combinationally, and ST stays 1 throughout.
- **TH write during reload:** old TH=5, write TH=9 in the overflow cycle. Required: TL=5 after the reload; the next reload gives TL=9.
- **Decode:** read `BASE_ADDR`+0x10, and read `BASE_ADDR`+0x20 with `MemRead`=1. Required: `ReadData`=0 for both; a write to SYSTICK leaves it counting unchanged.
